// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pc_state_e;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry and the count saturates.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_ptr;     // next free slot; top lives at r_ptr-1
    logic [PW:0]     r_cnt;
    logic [PW-1:0]   w_top_idx;
    logic            w_empty;

    assign w_top_idx = r_ptr - 1'b1;
    assign w_empty   = (r_cnt == '0);
    assign o_empty   = w_empty;
    assign o_top     = w_empty ? '0 : r_mem[w_top_idx];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push && (!i_pop || w_empty)) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_cnt != (PW+1)'(RAS_DEPTH))
                r_cnt <= r_cnt + 1'b1;
        end else if (i_pop && !i_push && !w_empty) begin
            r_ptr <= w_top_idx;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Storage has no reset; push+pop on a non-empty stack rewrites the top in place.
    always_ff @(posedge i_clock) begin
        if (i_push) begin
            if (i_pop && !w_empty)
                r_mem[w_top_idx] <= i_data;
            else
                r_mem[r_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot/run/fault sequencing, branch/jalr target, trap redirect.
// Optional return-address stack compiled in with macro PC_UNIT_RAS_EN.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    output logic            o_fetch_valid,
    input  logic            i_fetch_ready,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic            i_use_base,
    input  logic [XLEN-1:0] i_redirect_base,
    input  logic [XLEN-1:0] i_redirect_imm,
    input  logic            i_trap_req,
    input  logic [XLEN-1:0] i_trap_vector,
    input  logic            i_ras_push,
    input  logic            i_ras_pop,
    output logic [XLEN-1:0] o_ras_top,
    output logic            o_ras_empty,
    output logic [XLEN-1:0] o_pc_out,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_target,
    output logic            o_misaligned_fault,
    output logic [XLEN-1:0] o_fault_addr
);
    pc_state_e       r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_fault_addr, w_fault_addr_nxt;
    logic [XLEN-1:0] w_sum, w_target, w_pc_plus4;

    assign w_sum      = (i_use_base ? i_redirect_base : r_pc) + i_redirect_imm;
    assign w_target   = i_use_base ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
    assign w_pc_plus4 = r_pc + XLEN'(PC_STEP);

    assign o_pc_out           = r_pc;
    assign o_pc_plus4         = w_pc_plus4;
    assign o_target           = w_target;
    assign o_fetch_valid      = (r_state == RUN);
    assign o_misaligned_fault = (r_state == FAULT);
    assign o_fault_addr       = r_fault_addr;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_fault_addr_nxt = r_fault_addr;
        if (i_trap_req) begin
            w_pc_nxt    = i_trap_vector;
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                BOOT: w_state_nxt = RUN;
                RUN: begin
                    // Redirects ignore stall/ready; only sequential advance waits on fetch.
                    if (i_branch_taken) begin
                        if (w_target[1:0] == 2'b00) begin
                            w_pc_nxt = w_target;
                        end else begin
                            w_fault_addr_nxt = w_target;
                            w_state_nxt      = FAULT;
                        end
                    end else if (i_fetch_ready && !i_stall) begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= BOOT;
            r_pc         <= RESET_VECTOR;
            r_fault_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_fault_addr <= w_fault_addr_nxt;
        end
    end

`ifdef PC_UNIT_RAS_EN
    logic w_ras_en;
    assign w_ras_en = (r_state != FAULT);

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_push    (i_ras_push && w_ras_en),
        .i_pop     (i_ras_pop && w_ras_en),
        .i_data    (w_pc_plus4),
        .o_top     (o_ras_top),
        .o_empty   (o_ras_empty)
    );
`else
    logic w_unused_ras;
    assign w_unused_ras = i_ras_push ^ i_ras_pop;
    assign o_ras_top    = '0;
    assign o_ras_empty  = 1'b1;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Randomized bench for pc_unit against a behavioural next-PC / stack model.
module tb_pc_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fetch_ready, stall, branch_taken, use_base, trap_req;
    logic            ras_push, ras_pop;
    logic [XLEN-1:0] redirect_base, redirect_imm, trap_vector;
    logic            fetch_valid, ras_empty, misaligned_fault;
    logic [XLEN-1:0] ras_top, pc_out, pc_plus4, target, fault_addr;

    always #5 clk = ~clk;

    pc_unit #(.XLEN(XLEN), .RESET_VECTOR('0), .RAS_DEPTH(DEPTH)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .o_fetch_valid(fetch_valid), .i_fetch_ready(fetch_ready), .i_stall(stall),
        .i_branch_taken(branch_taken), .i_use_base(use_base),
        .i_redirect_base(redirect_base), .i_redirect_imm(redirect_imm),
        .i_trap_req(trap_req), .i_trap_vector(trap_vector),
        .i_ras_push(ras_push), .i_ras_pop(ras_pop),
        .o_ras_top(ras_top), .o_ras_empty(ras_empty),
        .o_pc_out(pc_out), .o_pc_plus4(pc_plus4), .o_target(target),
        .o_misaligned_fault(misaligned_fault), .o_fault_addr(fault_addr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain PC value, two flags and a queue for the stack.
    bit              m_boot, m_fault;
    logic [XLEN-1:0] m_pc, m_faddr;
    logic [XLEN-1:0] m_ras[$];

    task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        fetch_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0; use_base = 1'b0;
        trap_req = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
        redirect_base = '0; redirect_imm = '0; trap_vector = '0;
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_fault = 1'b0; m_pc = '0; m_faddr = '0;
        m_ras.delete();
    endtask

    function automatic logic [XLEN-1:0] m_target();
        logic [XLEN-1:0] s;
        s = (use_base ? redirect_base : m_pc) + redirect_imm;
        if (use_base) s[0] = 1'b0;
        return s;
    endfunction

    // Called #1 after a rising edge with inputs already driven.
    task automatic step();
        logic [XLEN-1:0] tgt, p4, n_pc, n_faddr;
        bit n_boot, n_fault;
        @(negedge clk);
        tgt = m_target();
        p4  = m_pc + 32'd4;
        chk("pc_out", pc_out, m_pc);
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_boot && !m_fault});
        chk("pc_plus4", pc_plus4, p4);
        chk("target", target, tgt);
        chk("misaligned", {31'd0, misaligned_fault}, {31'd0, m_fault});
        chk("fault_addr", fault_addr, m_faddr);
        chk("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
        chk("ras_top", ras_top, (m_ras.size() == 0) ? '0 : m_ras[m_ras.size()-1]);
        n_pc = m_pc; n_faddr = m_faddr; n_boot = m_boot; n_fault = m_fault;
        if (trap_req) begin
            n_pc = trap_vector; n_boot = 1'b0; n_fault = 1'b0;
        end else if (m_boot) begin
            n_boot = 1'b0;
        end else if (!m_fault) begin
            if (branch_taken) begin
                if (tgt[1:0] == 2'b00) n_pc = tgt;
                else begin n_fault = 1'b1; n_faddr = tgt; end
            end else if (fetch_ready && !stall) begin
                n_pc = p4;
            end
        end
        if (RAS_EN && !m_fault) begin
            if (ras_push && ras_pop && m_ras.size() != 0) m_ras[m_ras.size()-1] = p4;
            else if (ras_push) begin
                m_ras.push_back(p4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (ras_pop && m_ras.size() != 0) void'(m_ras.pop_back());
        end
        @(posedge clk); #1;
        m_pc = n_pc; m_faddr = n_faddr; m_boot = n_boot; m_fault = n_fault;
    endtask

    task automatic trap_to(input logic [XLEN-1:0] v);
        idle(); trap_req = 1'b1; trap_vector = v; step(); idle();
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        chk("rst_pc", pc_out, '0);
        chk("rst_fv", {31'd0, fetch_valid}, '0);
        chk("rst_fault", {31'd0, misaligned_fault}, '0);
        chk("rst_faddr", fault_addr, '0);
        chk("rst_empty", {31'd0, ras_empty}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Boot cycle then sequential fetch 0,4,8.
        for (int i = 0; i < 4; i++) step();
        chk("seq_pc", pc_out, 32'hC);

        // Branch during stall.
        trap_to(32'h100);
        stall = 1'b1; branch_taken = 1'b1; redirect_imm = 32'h20; step(); idle();
        chk("br_stall", pc_out, 32'h120);

        // Misaligned jalr; branch and push while faulted are ignored.
        use_base = 1'b1; branch_taken = 1'b1; redirect_base = 32'h203; step();
        chk("mis_faddr", fault_addr, 32'h202);
        chk("mis_flag", {31'd0, misaligned_fault}, 32'd1);
        chk("mis_hold", pc_out, 32'h120);
        idle(); branch_taken = 1'b1; redirect_imm = 32'h40; ras_push = 1'b1; step(); idle();
        step();
        trap_to(32'h80);
        chk("trap_pc", pc_out, 32'h80);
        chk("trap_clr", {31'd0, misaligned_fault}, '0);

        // Trap wins over branch.
        trap_to(32'h1E0);
        trap_req = 1'b1; trap_vector = 32'h40; branch_taken = 1'b1; redirect_imm = 32'h20; step(); idle();
        chk("trap_prio", pc_out, 32'h40);

        // Overfill the stack, then drain it and pop once more.
        trap_to(32'h0);
        for (int i = 0; i < 5; i++) begin ras_push = 1'b1; step(); end
        idle();
        if (RAS_EN) chk("ras_full_top", ras_top, 32'h14);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin ras_pop = 1'b1; step(); end
        idle(); step();

        // PC wrap.
        trap_to(32'hFFFF_FFFC);
        step();
        chk("wrap", pc_out, 32'h0);

        // Random traffic with periodic asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            trap_req      = ($urandom_range(0, 15) == 0);
            trap_vector   = $urandom & 32'h0000_FFFC;
            branch_taken  = ($urandom_range(0, 3) == 0);
            use_base      = $urandom_range(0, 1);
            redirect_base = $urandom;
            redirect_imm  = $urandom & 32'h3FF;
            if ($urandom_range(0, 3) != 0) redirect_imm[1:0] = 2'b00;
            stall         = ($urandom_range(0, 3) == 0);
            fetch_ready   = ($urandom_range(0, 3) != 0);
            ras_push      = ($urandom_range(0, 2) == 0);
            ras_pop       = ($urandom_range(0, 2) == 0);
            step();
            if (i % 700 == 699) begin
                idle(); branch_taken = 1'b1; redirect_imm = 32'h10;
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                chk("arst_pc", pc_out, '0);
                chk("arst_fv", {31'd0, fetch_valid}, '0);
                chk("arst_fault", {31'd0, misaligned_fault}, '0);
                chk("arst_faddr", fault_addr, '0);
                chk("arst_empty", {31'd0, ras_empty}, 32'd1);
                @(posedge clk); #1;
                chk("arst_hold", pc_out, '0);
                rst_n = 1'b1;
                idle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/data width.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded by reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-004 SHALL have port clock  in  1  single clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports fetch_valid out 1 (pc_out requests fetch) and fetch_ready in 1 (fetch accepted).
REQ-007 SHALL have port stall  in  1  freezes sequential advance.
REQ-008 SHALL have ports branch_taken in 1, use_base in 1 (jalr form), redirect_base in XLEN, redirect_imm in XLEN.
REQ-009 SHALL have ports trap_req in 1, trap_vector in XLEN.
REQ-010 SHALL have ports ras_push in 1, ras_pop in 1, ras_top out XLEN, ras_empty out 1.
REQ-011 SHALL have ports pc_out out XLEN, pc_plus4 out XLEN, target out XLEN, misaligned_fault out 1, fault_addr out XLEN.

Function
REQ-012 SHALL compute target = (use_base ? redirect_base : pc_out) + redirect_imm modulo 2^XLEN, bit 0 cleared when use_base=1; pc_plus4 = pc_out+4 modulo 2^XLEN (wraps all-ones-3 to 0).
REQ-013 SHALL implement FSM states BOOT, RUN, FAULT.
REQ-014 BOOT: fetch_valid=0 for exactly one cycle after reset release, then RUN.
REQ-015 RUN: fetch_valid=1; next PC priority trap_req > branch_taken > sequential.
REQ-016 trap_req (any state) SHALL load trap_vector next cycle and enter RUN, clearing misaligned_fault.
REQ-017 branch_taken with target[1:0]==0 SHALL load target next cycle regardless of stall or fetch_ready.
REQ-018 branch_taken with target[1:0]!=0 SHALL hold pc_out, latch target into fault_addr, assert misaligned_fault, enter FAULT.
REQ-019 Sequential advance to pc_plus4 SHALL occur only when fetch_valid & fetch_ready & !stall; otherwise pc_out holds.
REQ-020 FAULT: fetch_valid=0, pc_out held, branch_taken and ras_* ignored; exit only via trap_req.
REQ-021 ras_push SHALL store pc_plus4 at top; push when full overwrites oldest entry (circular), count saturates at RAS_DEPTH.
REQ-022 ras_pop on non-empty SHALL remove top next cycle; pop on empty SHALL be a no-op.
REQ-023 ras_push and ras_pop in same cycle SHALL replace top with pc_plus4, count unchanged (push-only if empty).
REQ-024 ras_top SHALL be the current top combinationally, 0 when ras_empty=1.

Reset
REQ-025 Reset low SHALL immediately set pc_out=RESET_VECTOR, state BOOT, fetch_valid=0, misaligned_fault=0, fault_addr=0, RAS count=0 (ras_empty=1), regardless of state, including mid-redirect.
REQ-026 RAS storage contents need not reset; only count/pointer.

Configuration
REQ-027 Macro PC_UNIT_RAS_EN SHALL compile in the RAS (REQ-021..024).
REQ-028 Without PC_UNIT_RAS_EN: no RAS storage, ras_push/ras_pop ignored, ras_top=0, ras_empty=1 constantly; all other behaviour identical.

Structure
REQ-029 Shared package pc_unit_pkg SHALL hold FSM state enum (BOOT, RUN, FAULT) and constant PC_STEP=4.
REQ-030 RAS SHALL be sub-module pc_ras (parameters XLEN, RAS_DEPTH); target/next-PC logic stays in pc_unit.

Verification
REQ-031 Reset release, fetch_ready=1 -> cycle 1 fetch_valid=0, pc_out=0; then 0,4,8 on consecutive cycles.
REQ-032 pc_out=0x100, stall=1, branch_taken=1, use_base=0, imm=0x20 -> next pc_out=0x120.
REQ-033 use_base=1, base=0x203, imm=0 -> target=0x202, misaligned_fault=1, fault_addr=0x202, pc_out held; trap_req with vector 0x80 -> pc_out=0x80, fault cleared.
REQ-034 trap_req and branch_taken same cycle, vector 0x40, target 0x200 -> pc_out=0x40.
REQ-035 RAS_DEPTH=4, 5 pushes at pc 0x0,0x4,0x8,0xC,0x10 -> ras_top=0x14; 4 pops -> entry 0x4 lost, ras_empty=1; further pop no-op.
REQ-036 pc_out=0xFFFFFFFC, advance -> pc_out=0x0; reset asserted mid-cycle -> pc_out=RESET_VECTOR asynchronously.
